// File: rtl/output_buffer_drain.sv
// Result sink and drain for the accumulator stream: captures writes into a
// DEPTH x DATA_W store and streams an address range out over valid/ready.
// Optional: define OBUF_SKIP_EMPTY_EN to make the drain skip entries whose valid bit is clear.
module output_buffer_drain #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              output_buffer_enable,
  input  logic [ADDR_W-1:0] output_buffer_addr,
  input  logic [DATA_W-1:0] output_data,
  input  logic              drain_start,
  input  logic [ADDR_W-1:0] drain_base,
  input  logic [ADDR_W:0]   drain_count,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              busy,
  output logic              drain_done,
  output logic              ovw_flag,
  output logic [1:0]        dbg_state_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_SEND  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_W:0] DEPTH_C = DEPTH[ADDR_W:0];
  localparam logic [ADDR_W:0] REM_ONE = {{ADDR_W{1'b0}}, 1'b1};

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]  vld_q;
  state_t            state_q;
  logic [ADDR_W-1:0] ptr_q;
  logic [ADDR_W:0]   rem_q;
  logic              rd_valid_q;
  logic [DATA_W-1:0] rd_data_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic              busy_q;
  logic              done_q;
  logic              ovw_q;
  logic [ADDR_W:0]   count_d;
  logic              skip_d;

  assign count_d = (drain_count > DEPTH_C) ? DEPTH_C : drain_count;

`ifdef OBUF_SKIP_EMPTY_EN
  assign skip_d = ~vld_q[ptr_q];
`else
  assign skip_d = 1'b0;
`endif

  // Storage has no reset; only the valid bits are cleared.
  always_ff @(posedge clk) begin
    if (output_buffer_enable) begin
      mem_q[output_buffer_addr] <= output_data;
    end
  end

  // Read port: rd_valid rises entering SEND and, once high, rd_valid, rd_data and
  // rd_addr hold until the edge where rd_valid && rd_ready (the only transfer point).
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      rem_q      <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      rd_addr_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ovw_q      <= 1'b0;
      vld_q      <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (drain_start) begin
            ptr_q <= drain_base;
            rem_q <= count_d;
            ovw_q <= 1'b0;
            if (count_d == '0) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_FETCH;
              busy_q  <= 1'b1;
            end
          end
        end
        ST_FETCH: begin
          if (skip_d) begin
            ptr_q <= ptr_q + 1'b1;
            rem_q <= rem_q - 1'b1;
            if (rem_q == REM_ONE) begin
              state_q <= ST_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end else begin
            rd_data_q  <= mem_q[ptr_q];
            rd_addr_q  <= ptr_q;
            rd_valid_q <= 1'b1;
            state_q    <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (rd_valid_q && rd_ready) begin
            rd_valid_q   <= 1'b0;
            vld_q[ptr_q] <= 1'b0;
            ptr_q        <= ptr_q + 1'b1;
            rem_q        <= rem_q - 1'b1;
            if (rem_q == REM_ONE) begin
              state_q <= ST_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_FETCH;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
      // A write lands after the drain's clear so a same-edge write keeps the entry valid.
      if (output_buffer_enable) begin
        vld_q[output_buffer_addr] <= 1'b1;
        if (vld_q[output_buffer_addr]) begin
          ovw_q <= 1'b1;
        end
      end
    end
  end

  assign rd_valid    = rd_valid_q;
  assign rd_data     = rd_data_q;
  assign rd_addr     = rd_addr_q;
  assign busy        = busy_q;
  assign drain_done  = done_q;
  assign ovw_flag    = ovw_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_output_buffer_drain.sv
// Randomized bench for output_buffer_drain against an array/queue reference model.
`timescale 1ns/1ps
module tb_output_buffer_drain;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              output_buffer_enable;
  logic [ADDR_W-1:0] output_buffer_addr;
  logic [DATA_W-1:0] output_data;
  logic              drain_start;
  logic [ADDR_W-1:0] drain_base;
  logic [ADDR_W:0]   drain_count;
  logic              rd_valid;
  logic              rd_ready;
  logic [DATA_W-1:0] rd_data;
  logic [ADDR_W-1:0] rd_addr;
  logic              busy;
  logic              drain_done;
  logic              ovw_flag;
  logic [1:0]        dbg_state_o;

  always #5 clk = ~clk;

  output_buffer_drain #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .output_buffer_enable(output_buffer_enable),
    .output_buffer_addr(output_buffer_addr),
    .output_data(output_data),
    .drain_start(drain_start), .drain_base(drain_base), .drain_count(drain_count),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_addr(rd_addr),
    .busy(busy), .drain_done(drain_done), .ovw_flag(ovw_flag),
    .dbg_state_o(dbg_state_o)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [DATA_W-1:0] m_mem [DEPTH];
  logic              m_vld [DEPTH];
  logic              m_ovw;
  logic [DATA_W-1:0] exp_q[$];
  logic [ADDR_W-1:0] exp_addr_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic bit emits(input logic [ADDR_W-1:0] a);
`ifdef OBUF_SKIP_EMPTY_EN
    return m_vld[a];
`else
    return 1'b1;
`endif
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_vld[i] = 1'b0;
    m_ovw = 1'b0;
  endtask

  task automatic check_zero_outputs(input string tag);
    check_eq({tag, "_rd_valid"}, 32'(rd_valid), 32'd0);
    check_eq({tag, "_rd_data"}, rd_data, 32'd0);
    check_eq({tag, "_rd_addr"}, 32'(rd_addr), 32'd0);
    check_eq({tag, "_busy"}, 32'(busy), 32'd0);
    check_eq({tag, "_drain_done"}, 32'(drain_done), 32'd0);
    check_eq({tag, "_ovw_flag"}, 32'(ovw_flag), 32'd0);
    check_eq({tag, "_state"}, 32'(dbg_state_o), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_zero_outputs("reset");
    rst = 1'b0;
    model_reset();
  endtask

  task automatic wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    @(negedge clk);
    output_buffer_enable = 1'b1;
    output_buffer_addr   = a;
    output_data          = d;
    if (m_vld[a]) m_ovw = 1'b1;
    m_vld[a] = 1'b1;
    m_mem[a] = d;
    @(negedge clk);
    output_buffer_enable = 1'b0;
    check_eq("ovw_after_wr", 32'(ovw_flag), 32'(m_ovw));
  endtask

  // ready_mode 0: always ready, 1: random. stall: cycles to refuse the first presented beat.
  task automatic drain(input logic [ADDR_W-1:0] base, input logic [ADDR_W:0] count,
                       input int ready_mode, input int stall, input bit bg);
    int n, trail, k_hs, stall_left;
    bit first_emit, done_seen, prev_valid, prev_ready;
    logic in_rng [DEPTH];
    logic [DATA_W-1:0] prev_data, ed;
    logic [ADDR_W-1:0] prev_addr, a, ea;
    n = (count > 5'd16) ? DEPTH : int'(count);
    trail = 0; first_emit = 1'b0; done_seen = 1'b0; k_hs = 0; stall_left = stall;
    prev_valid = 1'b0; prev_ready = 1'b0; prev_data = '0; prev_addr = '0;
    exp_q.delete(); exp_addr_q.delete();
    for (int i = 0; i < DEPTH; i++) in_rng[i] = 1'b0;
    for (int i = 0; i < n; i++) begin
      a = base + ADDR_W'(i);
      in_rng[a] = 1'b1;
      if (emits(a)) begin
        exp_q.push_back(m_mem[a]);
        exp_addr_q.push_back(a);
        trail = 0;
        if (i == 0) first_emit = 1'b1;
      end else begin
        trail++;
      end
    end
    for (int i = 0; i < DEPTH; i++) if (in_rng[i]) m_vld[i] = 1'b0;
    m_ovw = 1'b0;
    @(negedge clk);
    drain_start = 1'b1; drain_base = base; drain_count = count; rd_ready = 1'b0;
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      drain_start = 1'b0;
      output_buffer_enable = 1'b0;
      if (k == 1) check_eq("busy_after_start", 32'(busy), 32'(n > 0));
      if (k == 2 && n > 0) check_eq("first_valid_latency", 32'(rd_valid), 32'(first_emit));
      if (prev_valid && !prev_ready) begin
        check_eq("stall_valid", 32'(rd_valid), 32'd1);
        check_eq("stall_data", rd_data, prev_data);
        check_eq("stall_addr", 32'(rd_addr), 32'(prev_addr));
      end
      if (drain_done) begin
        done_seen = 1'b1;
        check_eq("busy_at_done", 32'(busy), 32'd0);
        if (n == 0) check_eq("empty_done_latency", 32'(k), 32'd1);
        if (k_hs > 0) check_eq("done_after_last_beat", 32'(k), 32'(k_hs + 1 + trail));
        break;
      end
      check_eq("busy_mid", 32'(busy), 32'd1);
      if (rd_valid && stall_left > 0) begin
        rd_ready = 1'b0;
        stall_left--;
      end else begin
        rd_ready = (ready_mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
      end
      if (rd_valid && rd_ready) begin
        if (exp_q.size() == 0) begin
          check_eq("extra_beat", 32'd1, 32'd0);
        end else begin
          ed = exp_q.pop_front();
          ea = exp_addr_q.pop_front();
          check_eq("beat_addr", 32'(rd_addr), 32'(ea));
          check_eq("beat_data", rd_data, ed);
        end
        k_hs = k;
      end
      prev_valid = rd_valid; prev_ready = rd_ready; prev_data = rd_data; prev_addr = rd_addr;
      if (bg && n < DEPTH && $urandom_range(0, 2) == 0) begin
        do a = ADDR_W'($urandom_range(0, DEPTH - 1)); while (in_rng[a]);
        output_buffer_enable = 1'b1;
        output_buffer_addr   = a;
        output_data          = $urandom;
        if (m_vld[a]) m_ovw = 1'b1;
        m_vld[a] = 1'b1;
        m_mem[a] = output_data;
      end
      if (bg && $urandom_range(0, 7) == 0) begin
        drain_start = 1'b1;
        drain_base  = ADDR_W'($urandom_range(0, DEPTH - 1));
        drain_count = 5'($urandom_range(1, DEPTH));
      end
    end
    if (!done_seen) check_eq("drain_timeout", 32'd0, 32'd1);
    rd_ready = 1'b0; drain_start = 1'b0; output_buffer_enable = 1'b0;
    @(negedge clk);
    check_eq("done_pulse_width", 32'(drain_done), 32'd0);
    check_eq("busy_after_done", 32'(busy), 32'd0);
    check_eq("ovw_after_drain", 32'(ovw_flag), 32'(m_ovw));
    check_eq("beats_left", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic reset_mid_drain();
    bit got;
    got = 1'b0;
    @(negedge clk);
    drain_start = 1'b1; drain_base = 4'd8; drain_count = 5'd4; rd_ready = 1'b1;
    @(negedge clk);
    drain_start = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (rd_valid) begin
        check_eq("abort_beat_addr", 32'(rd_addr), 32'd8);
        check_eq("abort_beat_data", rd_data, m_mem[8]);
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!got) check_eq("abort_first_beat_timeout", 32'd0, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_zero_outputs("abort");
    rst = 1'b0; rd_ready = 1'b0;
    model_reset();
    repeat (5) begin
      @(negedge clk);
      check_eq("abort_no_done", 32'(drain_done), 32'd0);
      check_eq("abort_no_valid", 32'(rd_valid), 32'd0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; output_buffer_enable = 1'b0; output_buffer_addr = '0; output_data = '0;
    drain_start = 1'b0; drain_base = '0; drain_count = '0; rd_ready = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_zero_outputs("por");
    rst = 1'b0;

    for (int i = 0; i < DEPTH; i++) wr(ADDR_W'(i), $urandom);
    do_reset();

    wr(4'd2, 32'h3F80_0000);
    wr(4'd3, 32'h4000_0000);
    drain(4'd2, 5'd2, 0, 0, 1'b0);
    wr(4'd2, 32'h0000_1234);

    wr(4'd9, 32'hCAFE_F00D);
    drain(4'd9, 5'd1, 0, 5, 1'b0);

    wr(4'd14, 32'hA); wr(4'd15, 32'hB); wr(4'd0, 32'hC); wr(4'd1, 32'hD);
    drain(4'd14, 5'd4, 0, 0, 1'b0);

    wr(4'd5, 32'h55); wr(4'd5, 32'h56);
    drain(4'd0, 5'd0, 0, 0, 1'b0);

    wr(4'd8, 32'h80); wr(4'd9, 32'h90); wr(4'd10, 32'hA0); wr(4'd11, 32'hB0);
    reset_mid_drain();

    do_reset();
    wr(4'd7, 32'h7777_0007);
    drain(4'd4, 5'd8, 0, 0, 1'b0);

    for (int i = 0; i < 6; i++) wr(ADDR_W'($urandom_range(0, DEPTH - 1)), $urandom);
    drain(4'd3, 5'd20, 1, 0, 1'b0);

    repeat (40) begin
      repeat ($urandom_range(0, 6)) wr(ADDR_W'($urandom_range(0, DEPTH - 1)), $urandom);
      drain(ADDR_W'($urandom_range(0, DEPTH - 1)), 5'($urandom_range(0, 20)), 1,
            $urandom_range(0, 3), 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
